stack_ctrl: RTL and testbench



---
 rtl/stack_ctrl_if.sv | 43 ++++
 rtl/stack_ctrl.sv | 157 +++++++++++++++
 tb/tb_stack_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if
// Groups the signals between the stack controller and its neighbours:
// the control unit (push/pop requests, data, status pulses), the stack
// pointer register (current value in, one-cycle move strobes out) and the
// data memory (single-word request/ack port).
//
// Modports:
//   master - the stack controller itself; it drives status, SP strobes
//            and the memory request
//   slave  - everything around it: control unit, SP register and memory
interface stack_ctrl_if;
  logic        STK_push;
  logic        STK_pop;
  logic [15:0] STK_din;
  logic [15:0] STK_dout;
  logic        STK_busy;
  logic        STK_done;
  logic        STK_ovf;
  logic        STK_unf;
  logic [15:0] STK_SP_in;
  logic        STK_SP_inc;
  logic        STK_SP_dec;
  logic [15:0] STK_mem_addr;
  logic [15:0] STK_mem_wdata;
  logic        STK_mem_req;
  logic        STK_mem_we;
  logic [15:0] STK_mem_rdata;
  logic        STK_mem_ack;

  modport master (
    input  STK_push, STK_pop, STK_din, STK_SP_in, STK_mem_rdata, STK_mem_ack,
    output STK_dout, STK_busy, STK_done, STK_ovf, STK_unf,
           STK_SP_inc, STK_SP_dec,
           STK_mem_addr, STK_mem_wdata, STK_mem_req, STK_mem_we
  );

  modport slave (
    output STK_push, STK_pop, STK_din, STK_SP_in, STK_mem_rdata, STK_mem_ack,
    input  STK_dout, STK_busy, STK_done, STK_ovf, STK_unf,
           STK_SP_inc, STK_SP_dec,
           STK_mem_addr, STK_mem_wdata, STK_mem_req, STK_mem_we
  );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl
// Stack controller in front of the 16-bit stack pointer register. Takes
// single-word push/pop requests, performs the memory access at the current
// stack address and pulses the SP move strobes. The stack is empty-
// descending: SP points at the next free word, so a push writes at SP and
// then moves SP down, while a pop moves SP up first and then reads at it.
// Overflow and underflow are detected in IDLE, before any memory access.
//
// Parameters:
//   STACK_TOP   - SP value of an empty stack (SP power-up value)
//   STACK_LIMIT - lowest address a push may write
//
// Ports:
//   STK_clk   - clock, rising edge
//   STK_rst_n - asynchronous active-low reset (does not touch the SP)
//   stk       - stack_ctrl_if.master: requests, status pulses, SP strobes,
//               memory port
module stack_ctrl #(
  parameter logic [15:0] STACK_TOP   = 16'hFFFF,
  parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
  input logic          STK_clk,
  input logic          STK_rst_n,
  stack_ctrl_if.master stk
);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_WR,
    PUSH_ADJ,
    POP_ADJ,
    POP_RD,
    POP_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] wr_data_q;
  logic [15:0] dout_q;
  logic        ovf_q, unf_q;

  logic        is_idle, is_empty, is_full;
  logic        accept_push, reject_push, accept_pop, reject_pop;

  logic        busy, done, sp_inc, sp_dec, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;

  // Push wins over pop when both are requested; requests outside IDLE
  // are simply dropped.
  assign is_idle     = (state_q == IDLE);
  assign is_empty    = (stk.STK_SP_in == STACK_TOP);
  assign is_full     = (stk.STK_SP_in < STACK_LIMIT);
  assign accept_push = is_idle &&  stk.STK_push && !is_full;
  assign reject_push = is_idle &&  stk.STK_push &&  is_full;
  assign accept_pop  = is_idle && !stk.STK_push && stk.STK_pop && !is_empty;
  assign reject_pop  = is_idle && !stk.STK_push && stk.STK_pop &&  is_empty;

  // State register.
  always_ff @(posedge STK_clk or negedge STK_rst_n) begin
    if (!STK_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: push data is frozen at acceptance so the write stays stable
  // while the memory stalls; popped data is held until the next pop ends.
  // The ovf/unf flags are registered so they land in the cycle after the
  // rejected request.
  always_ff @(posedge STK_clk or negedge STK_rst_n) begin
    if (!STK_rst_n) begin
      wr_data_q <= 16'h0000;
      dout_q    <= 16'h0000;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      if (accept_push) begin
        wr_data_q <= stk.STK_din;
      end
      if (state_q == POP_RD && stk.STK_mem_ack) begin
        dout_q <= stk.STK_mem_rdata;
      end
      ovf_q <= reject_push;
      unf_q <= reject_pop;
    end
  end

  // Next-state and per-state outputs. Address and write data are forced
  // to zero outside the memory states so nothing stale leaks onto the bus.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    done      = 1'b0;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (accept_push) begin
          state_d = PUSH_WR;
        end else if (accept_pop) begin
          state_d = POP_ADJ;
        end
      end
      PUSH_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = stk.STK_SP_in;
        mem_wdata = wr_data_q;
        if (stk.STK_mem_ack) begin
          state_d = PUSH_ADJ;
        end
      end
      PUSH_ADJ: begin
        sp_inc  = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      POP_ADJ: begin
        sp_dec  = 1'b1;
        state_d = POP_RD;
      end
      POP_RD: begin
        // SP has already moved up, so it now addresses the top word.
        mem_req  = 1'b1;
        mem_addr = stk.STK_SP_in;
        if (stk.STK_mem_ack) begin
          state_d = POP_FIN;
        end
      end
      POP_FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stk.STK_dout      = dout_q;
  assign stk.STK_busy      = busy;
  assign stk.STK_done      = done;
  assign stk.STK_ovf       = ovf_q;
  assign stk.STK_unf       = unf_q;
  assign stk.STK_SP_inc    = sp_inc;
  assign stk.STK_SP_dec    = sp_dec;
  assign stk.STK_mem_req   = mem_req;
  assign stk.STK_mem_we    = mem_we;
  assign stk.STK_mem_addr  = mem_addr;
  assign stk.STK_mem_wdata = mem_wdata;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl
// Directed bench for stack_ctrl built with a 4-word stack (STACK_LIMIT
// FFFC). Surrounds the controller with a stack pointer register model and
// a small memory with a programmable number of wait states, then walks
// through push/pop timing, underflow, overflow, LIFO order, push/pop
// priority, requests while busy and reset in the middle of a write.
module tb_stack_ctrl;

  logic STK_clk;
  logic STK_rst_n;

  stack_ctrl_if ifc ();

  stack_ctrl #(
    .STACK_TOP   (16'hFFFF),
    .STACK_LIMIT (16'hFFFC)
  ) dut (
    .STK_clk   (STK_clk),
    .STK_rst_n (STK_rst_n),
    .stk       (ifc)
  );

  // Free-running clock, period 10.
  initial begin
    STK_clk = 1'b0;
    forever #5 STK_clk = ~STK_clk;
  end

  // Stack pointer register: powers up at the empty value and is never
  // reset by the controller's reset.
  logic [15:0] sp = 16'hFFFF;
  always @(posedge STK_clk) begin
    if (ifc.STK_SP_inc) begin
      sp <= sp - 16'd1;
    end else if (ifc.STK_SP_dec) begin
      sp <= sp + 16'd1;
    end
  end
  assign ifc.STK_SP_in = sp;

  // Memory: acks after waitStates stalled cycles of a held request.
  logic [15:0] mem [16];
  int waitStates = 0;
  int waitCnt;
  int writeCount = 0;
  assign ifc.STK_mem_ack   = ifc.STK_mem_req && (waitCnt == waitStates);
  assign ifc.STK_mem_rdata = mem[ifc.STK_mem_addr[3:0]];

  always @(posedge STK_clk or negedge STK_rst_n) begin
    if (!STK_rst_n) begin
      waitCnt <= 0;
    end else if (ifc.STK_mem_req && !ifc.STK_mem_ack) begin
      waitCnt <= waitCnt + 1;
    end else begin
      waitCnt <= 0;
    end
  end

  always @(posedge STK_clk) begin
    if (ifc.STK_mem_req && ifc.STK_mem_ack && ifc.STK_mem_we) begin
      mem[ifc.STK_mem_addr[3:0]] <= ifc.STK_mem_wdata;
      writeCount <= writeCount + 1;
    end
  end

  // Pulse counters, sampled once per cycle.
  int incCount = 0;
  int decCount = 0;
  int doneCount = 0;
  int ovfCount = 0;
  int unfCount = 0;
  always @(posedge STK_clk) begin
    if (ifc.STK_SP_inc) incCount  <= incCount + 1;
    if (ifc.STK_SP_dec) decCount  <= decCount + 1;
    if (ifc.STK_done)   doneCount <= doneCount + 1;
    if (ifc.STK_ovf)    ovfCount  <= ovfCount + 1;
    if (ifc.STK_unf)    unfCount  <= unfCount + 1;
  end

  int checkCount = 0;
  int passCount = 0;

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive the request inputs on the falling edge.
  task automatic applyStimulus(input logic push, input logic pop,
                               input logic [15:0] din);
    @(negedge STK_clk);
    ifc.STK_push = push;
    ifc.STK_pop  = pop;
    ifc.STK_din  = din;
  endtask

  // Bounded wait for the controller to return to IDLE.
  task automatic waitIdle(input string tag);
    for (int i = 0; i < 40 && ifc.STK_busy; i++) @(negedge STK_clk);
    checkOutput(tag, {15'd0, ifc.STK_busy}, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [15:0] pushData [4];
  int lat;
  int incBefore, decBefore, doneBefore, writesBefore;

  initial begin
    pushData[0] = 16'h1111;
    pushData[1] = 16'h2222;
    pushData[2] = 16'h3333;
    pushData[3] = 16'h4444;
    ifc.STK_push = 1'b0;
    ifc.STK_pop  = 1'b0;
    ifc.STK_din  = 16'h0000;
    STK_rst_n    = 1'b0;

    // Reset state
    #12;
    checkOutput("rstBusy", {15'd0, ifc.STK_busy}, 16'h0000);
    checkOutput("rstReq",  {15'd0, ifc.STK_mem_req}, 16'h0000);
    checkOutput("rstDout", ifc.STK_dout, 16'h0000);
    checkOutput("rstAddr", ifc.STK_mem_addr, 16'h0000);
    checkOutput("rstStrb", {12'd0, ifc.STK_SP_inc, ifc.STK_SP_dec,
                            ifc.STK_ovf, ifc.STK_unf}, 16'h0000);
    @(negedge STK_clk);
    STK_rst_n = 1'b1;

    // Push A5A5 at SP=FFFF, zero-wait memory
    waitStates = 0;
    applyStimulus(1'b1, 1'b0, 16'hA5A5);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("pushWrReq",   {15'd0, ifc.STK_mem_req}, 16'h0001);
    checkOutput("pushWrWe",    {15'd0, ifc.STK_mem_we}, 16'h0001);
    checkOutput("pushWrAddr",  ifc.STK_mem_addr, 16'hFFFF);
    checkOutput("pushWrData",  ifc.STK_mem_wdata, 16'hA5A5);
    checkOutput("pushWrDone",  {15'd0, ifc.STK_done}, 16'h0000);
    @(negedge STK_clk);
    checkOutput("pushAdjInc",  {15'd0, ifc.STK_SP_inc}, 16'h0001);
    checkOutput("pushAdjDone", {15'd0, ifc.STK_done}, 16'h0001);
    checkOutput("pushAdjBusy", {15'd0, ifc.STK_busy}, 16'h0001);
    checkOutput("pushAdjReq",  {15'd0, ifc.STK_mem_req}, 16'h0000);
    @(negedge STK_clk);
    checkOutput("pushEndBusy", {15'd0, ifc.STK_busy}, 16'h0000);
    checkOutput("pushEndSp",   sp, 16'hFFFE);
    checkOutput("pushMem",     mem[15], 16'hA5A5);
    checkOutput("pushIncCnt",  16'(incCount), 16'd1);

    // Pop with two wait states
    waitStates = 2;
    applyStimulus(1'b0, 1'b1, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("popAdjDec",  {15'd0, ifc.STK_SP_dec}, 16'h0001);
    checkOutput("popAdjReq",  {15'd0, ifc.STK_mem_req}, 16'h0000);
    @(negedge STK_clk);
    checkOutput("popRdReq",   {15'd0, ifc.STK_mem_req}, 16'h0001);
    checkOutput("popRdWe",    {15'd0, ifc.STK_mem_we}, 16'h0000);
    checkOutput("popRdAddr",  ifc.STK_mem_addr, 16'hFFFF);
    lat = 2;
    while (!ifc.STK_done && lat < 20) begin
      @(negedge STK_clk);
      lat++;
    end
    checkOutput("popDoneLat", 16'(lat), 16'd5);
    checkOutput("popDout",    ifc.STK_dout, 16'hA5A5);
    @(negedge STK_clk);
    checkOutput("popEndBusy", {15'd0, ifc.STK_busy}, 16'h0000);
    checkOutput("popEndSp",   sp, 16'hFFFF);
    checkOutput("popDecCnt",  16'(decCount), 16'd1);

    // Pop on empty stack
    applyStimulus(1'b0, 1'b1, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("unfPulse", {15'd0, ifc.STK_unf}, 16'h0001);
    checkOutput("unfBusy",  {15'd0, ifc.STK_busy}, 16'h0000);
    checkOutput("unfReq",   {15'd0, ifc.STK_mem_req}, 16'h0000);
    @(negedge STK_clk);
    checkOutput("unfClear", {15'd0, ifc.STK_unf}, 16'h0000);
    @(negedge STK_clk);
    checkOutput("unfCnt",   16'(unfCount), 16'd1);
    checkOutput("unfDecCnt", 16'(decCount), 16'd1);

    // Fill the 4-word stack, then overflow
    waitStates = 1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, pushData[i]);
      applyStimulus(1'b0, 1'b0, 16'h0000);
      waitIdle("fillIdle");
    end
    checkOutput("fullSp",     sp, 16'hFFFB);
    checkOutput("fullWrites", 16'(writeCount), 16'd5);
    applyStimulus(1'b1, 1'b0, 16'h5555);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("ovfPulse", {15'd0, ifc.STK_ovf}, 16'h0001);
    checkOutput("ovfBusy",  {15'd0, ifc.STK_busy}, 16'h0000);
    checkOutput("ovfReq",   {15'd0, ifc.STK_mem_req}, 16'h0000);
    @(negedge STK_clk);
    checkOutput("ovfClear", {15'd0, ifc.STK_ovf}, 16'h0000);
    @(negedge STK_clk);
    checkOutput("ovfCnt",    16'(ovfCount), 16'd1);
    checkOutput("ovfWrites", 16'(writeCount), 16'd5);
    checkOutput("ovfIncCnt", 16'(incCount), 16'd5);
    checkOutput("ovfSp",     sp, 16'hFFFB);

    // Drain in LIFO order
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b1, 16'h0000);
      applyStimulus(1'b0, 1'b0, 16'h0000);
      waitIdle("drainIdle");
      checkOutput("lifoData", ifc.STK_dout, pushData[i]);
    end
    checkOutput("drainSp", sp, 16'hFFFF);

    // Push and pop together: push wins; pop pulses while busy are ignored
    waitStates = 3;
    incBefore  = incCount;
    decBefore  = decCount;
    doneBefore = doneCount;
    applyStimulus(1'b1, 1'b1, 16'hBEEF);
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checkOutput("prioWe",  {15'd0, ifc.STK_mem_we}, 16'h0001);
    checkOutput("prioDec", {15'd0, ifc.STK_SP_dec}, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    waitIdle("prioIdle");
    @(negedge STK_clk);
    @(negedge STK_clk);
    checkOutput("prioDoneCnt", 16'(doneCount - doneBefore), 16'd1);
    checkOutput("prioIncCnt",  16'(incCount - incBefore), 16'd1);
    checkOutput("prioDecCnt",  16'(decCount - decBefore), 16'd0);
    checkOutput("prioSp",      sp, 16'hFFFE);
    checkOutput("prioMem",     mem[15], 16'hBEEF);
    checkOutput("prioDout",    ifc.STK_dout, 16'h1111);

    // Reset in the middle of a stalled write
    incBefore    = incCount;
    writesBefore = writeCount;
    applyStimulus(1'b1, 1'b0, 16'h7777);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("rwReqBefore", {15'd0, ifc.STK_mem_req}, 16'h0001);
    #2;
    STK_rst_n = 1'b0;
    #1;
    checkOutput("rwReq",   {15'd0, ifc.STK_mem_req}, 16'h0000);
    checkOutput("rwBusy",  {15'd0, ifc.STK_busy}, 16'h0000);
    checkOutput("rwAddr",  ifc.STK_mem_addr, 16'h0000);
    checkOutput("rwWdata", ifc.STK_mem_wdata, 16'h0000);
    checkOutput("rwDout",  ifc.STK_dout, 16'h0000);
    checkOutput("rwStrb",  {14'd0, ifc.STK_SP_inc, ifc.STK_done}, 16'h0000);
    @(negedge STK_clk);
    @(negedge STK_clk);
    STK_rst_n = 1'b1;
    repeat (5) @(negedge STK_clk);
    checkOutput("rwIncCnt", 16'(incCount - incBefore), 16'd0);
    checkOutput("rwWrites", 16'(writeCount - writesBefore), 16'd0);
    checkOutput("rwSp",     sp, 16'hFFFE);
    checkOutput("rwIdle",   {15'd0, ifc.STK_busy}, 16'h0000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
